// File: rtl/bin2dec_pkg.sv
// Shared definitions for the BCD two-digit entry controller: FSM states,
// seven-segment constants and the decimal glyph lookup.
package bin2dec_pkg;

  // Entry sequence: tens digit, units digit, result shown, or bad digit seen
  typedef enum logic [1:0] {
    S_TENS  = 2'd0,
    S_UNITS = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  // Segments are active-low, bit6=g ... bit0=a
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  // Glyph for a decimal digit; any non-decimal code shows blank
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: two-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted press (released->pressed) transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic enter
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          db_r;
  logic [CW-1:0] cnt_r;
  logic          enter_r;

  // Bring the raw key into the clock domain; idle level is released (1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it has held for the full window; any
  // return to the current level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_r    <= 1'b1;
      cnt_r   <= '0;
      enter_r <= 1'b0;
    end else if (sync2_r != db_r) begin
      if (cnt_r == CNT_LAST) begin
        db_r    <= sync2_r;
        cnt_r   <= '0;
        enter_r <= db_r & ~sync2_r;
      end else begin
        cnt_r   <= cnt_r + CW'(1);
        enter_r <= 1'b0;
      end
    end else begin
      cnt_r   <= '0;
      enter_r <= 1'b0;
    end
  end

  assign enter = enter_r;

endmodule

// File: rtl/bcd_entry_ctrl.sv
// Two-digit BCD entry: the user presents a digit on SW and presses KEY1 for
// tens then units; the binary value and its digits are shown on LEDG/HEX.
module bcd_entry_ctrl
  import bin2dec_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic [3:0] SW,
  output logic [7:0] LEDG,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2
);

  logic       enter_s;
  state_t     state_r, state_s;
  logic [3:0] tens_r, tens_s;
  logic [3:0] units_r, units_s;
  logic [6:0] result_s;
  logic [7:0] ledg_r, ledg_s;
  logic [6:0] hex0_r, hex0_s;
  logic [6:0] hex1_r, hex1_s;
  logic [6:0] hex2_r, hex2_s;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (CLOCK_50),
    .rst_n (KEY0),
    .key_n (KEY1),
    .enter (enter_s)
  );

  // State and captured digits
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_r <= S_TENS;
      tens_r  <= 4'd0;
      units_r <= 4'd0;
    end else begin
      state_r <= state_s;
      tens_r  <= tens_s;
      units_r <= units_s;
    end
  end

  // Next state: moves only on an enter pulse; non-decimal digits go to error
  always_comb begin
    state_s = state_r;
    tens_s  = tens_r;
    units_s = units_r;
    if (enter_s) begin
      case (state_r)
        S_TENS: begin
          if (SW <= 4'd9) begin
            tens_s  = SW;
            state_s = S_UNITS;
          end else begin
            state_s = S_ERR;
          end
        end
        S_UNITS: begin
          if (SW <= 4'd9) begin
            units_s = SW;
            state_s = S_DONE;
          end else begin
            state_s = S_ERR;
          end
        end
        S_DONE, S_ERR: begin
          tens_s  = 4'd0;
          units_s = 4'd0;
          state_s = S_TENS;
        end
        default: begin
          tens_s  = 4'd0;
          units_s = 4'd0;
          state_s = S_TENS;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // tens*10 + units as shift-add; 9*10+9 fits in 7 bits
  assign result_s = ({3'b000, tens_r} << 3) + ({3'b000, tens_r} << 1)
                  + {3'b000, units_r};

  // Display decode from the current state; a leading 0 tens digit is shown
  always_comb begin
    ledg_s = 8'd0;
    hex2_s = SEG_BLANK;
    hex1_s = SEG_BLANK;
    hex0_s = SEG_BLANK;
    case (state_r)
      S_TENS: begin
        ledg_s = 8'd0;
      end
      S_UNITS: begin
        hex1_s = seg7(tens_r);
      end
      S_DONE: begin
        hex1_s = seg7(tens_r);
        hex0_s = seg7(units_r);
        ledg_s = {1'b1, result_s};
      end
      S_ERR: begin
        hex2_s = SEG_E;
        hex1_s = SEG_R;
        hex0_s = SEG_R;
      end
      default: begin
        ledg_s = 8'd0;
      end
    endcase
  end

  // Registered outputs, one cycle behind the state register
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      ledg_r <= 8'd0;
      hex2_r <= SEG_BLANK;
      hex1_r <= SEG_BLANK;
      hex0_r <= SEG_BLANK;
    end else begin
      ledg_r <= ledg_s;
      hex2_r <= hex2_s;
      hex1_r <= hex1_s;
      hex0_r <= hex0_s;
    end
  end

  assign LEDG = ledg_r;
  assign HEX2 = hex2_r;
  assign HEX1 = hex1_r;
  assign HEX0 = hex0_r;

endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Scoreboard bench: each stimulus step pushes the display it should produce;
// a monitor pops and compares every time the outputs change.
module tb_bcd_entry_ctrl;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GR = 7'b0101111;
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;

  typedef struct packed {
    logic [7:0] ledg;
    logic [6:0] h2;
    logic [6:0] h1;
    logic [6:0] h0;
  } disp_t;

  logic       CLOCK_50 = 1'b0;
  logic       KEY0 = 1'b0;
  logic       KEY1 = 1'b1;
  logic [3:0] SW = 4'd0;
  logic [7:0] LEDG;
  logic [6:0] HEX0, HEX1, HEX2;

  disp_t exp_q[$];
  int    tests_run = 0;
  int    fail_cnt  = 0;
  int    pulse_cnt = 0;
  bit    mon_en    = 1'b0;
  disp_t prev_d;

  bcd_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .KEY1     (KEY1),
    .SW       (SW),
    .LEDG     (LEDG),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (dut.u_key_debounce.enter) pulse_cnt <= pulse_cnt + 1;
  end

  function automatic disp_t mk(input logic [7:0] l, input logic [6:0] a,
                               input logic [6:0] b, input logic [6:0] c);
    disp_t d;
    d.ledg = l; d.h2 = a; d.h1 = b; d.h0 = c;
    return d;
  endfunction

  task automatic check(input string name, input disp_t act, input disp_t req);
    tests_run++;
    if (act !== req) begin
      fail_cnt++;
      $display("FAIL %s: got LEDG=%b HEX2=%b HEX1=%b HEX0=%b, want LEDG=%b HEX2=%b HEX1=%b HEX0=%b",
               name, act.ledg, act.h2, act.h1, act.h0, req.ledg, req.h2, req.h1, req.h0);
    end
  endtask

  function automatic disp_t cur();
    return mk(LEDG, HEX2, HEX1, HEX0);
  endfunction

  // Monitor: every output change consumes one expected display
  always @(negedge CLOCK_50) begin
    disp_t now_d;
    now_d = cur();
    if (mon_en && (now_d !== prev_d)) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        fail_cnt++;
        $display("FAIL unexpected_change: got LEDG=%b HEX2=%b HEX1=%b HEX0=%b, want no change",
                 now_d.ledg, now_d.h2, now_d.h1, now_d.h0);
      end else begin
        check("scoreboard", now_d, exp_q.pop_front());
      end
    end
    prev_d = now_d;
  end

  task automatic press(input logic [3:0] d, input disp_t e);
    exp_q.push_back(e);
    @(posedge CLOCK_50); #1;
    SW = d;
    KEY1 = 1'b0;
    repeat (12) @(posedge CLOCK_50);
    #1 KEY1 = 1'b1;
    repeat (12) @(posedge CLOCK_50);
  endtask

  initial begin
    disp_t blank_d;
    blank_d = mk(8'd0, BL, BL, BL);
    prev_d  = blank_d;
    #35;
    check("reset_state", cur(), blank_d);
    KEY0 = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    mon_en = 1'b1;

    // 47 entry, then clear (SW ignored on the clearing press)
    press(4'd4,  mk(8'd0, BL, G4, BL));
    press(4'd7,  mk(8'b1010_1111, BL, G4, G7));
    press(4'd15, blank_d);

    // 99 entry and clear
    press(4'd9, mk(8'd0, BL, G9, BL));
    press(4'd9, mk(8'hE3, BL, G9, G9));
    press(4'd9, blank_d);

    // bad tens digit, clear; bad units digit after tens=3, clear
    press(4'd12, mk(8'd0, GE, GR, GR));
    press(4'd0,  blank_d);
    press(4'd3,  mk(8'd0, BL, G3, BL));
    press(4'd10, mk(8'd0, GE, GR, GR));
    press(4'd3,  blank_d);

    // SW wiggling alone must not move anything
    for (int i = 0; i < 8; i++) begin
      @(posedge CLOCK_50); #1 SW = 4'(i * 3);
    end
    repeat (6) @(posedge CLOCK_50);
    check("sw_no_effect", cur(), blank_d);

    // bouncing key: one press only
    exp_q.push_back(mk(8'd0, BL, G2, BL));
    @(posedge CLOCK_50); #1 SW = 4'd2;
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      KEY1 = ~KEY1;
      repeat (2) @(posedge CLOCK_50);
      #1;
    end
    KEY1 = 1'b0;
    repeat (10) @(posedge CLOCK_50);
    tests_run++;
    if (pulse_cnt != 1) begin
      fail_cnt++;
      $display("FAIL bounce_one_pulse: got %0d pulses, want 1", pulse_cnt);
    end
    repeat (100) @(posedge CLOCK_50);
    #1 KEY1 = 1'b1;
    repeat (12) @(posedge CLOCK_50);
    tests_run++;
    if (pulse_cnt != 1) begin
      fail_cnt++;
      $display("FAIL hold_release_no_pulse: got %0d pulses, want 1", pulse_cnt);
    end

    // reach S_UNITS with tens=5, then reset mid-entry
    press(4'd5, mk(8'h99, BL, G2, G5));
    press(4'd0, blank_d);
    press(4'd5, mk(8'd0, BL, G5, BL));
    exp_q.push_back(blank_d);
    @(posedge CLOCK_50); #3;
    KEY0 = 1'b0;
    #1;
    check("async_reset", cur(), blank_d);
    repeat (3) @(posedge CLOCK_50);
    #1 KEY0 = 1'b1;
    press(4'd0, mk(8'd0, BL, G0, BL));
    press(4'd0, mk(8'b1000_0000, BL, G0, G0));

    // key held low through reset release still yields one press
    exp_q.push_back(blank_d);
    @(posedge CLOCK_50); #1;
    KEY0 = 1'b0;
    KEY1 = 1'b0;
    SW = 4'd6;
    repeat (3) @(posedge CLOCK_50);
    pulse_cnt = 0;
    exp_q.push_back(mk(8'd0, BL, G6, BL));
    #1 KEY0 = 1'b1;
    repeat (15) @(posedge CLOCK_50);
    #1 KEY1 = 1'b1;
    repeat (12) @(posedge CLOCK_50);
    tests_run++;
    if (pulse_cnt != 1) begin
      fail_cnt++;
      $display("FAIL held_through_reset: got %0d pulses, want 1", pulse_cnt);
    end

    // everything expected must have been seen
    repeat (4) @(posedge CLOCK_50);
    tests_run++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL pending_expect: got %0d unconsumed, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
